fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 SHALL have parameter AWIDTH, default 16, instruction address width.
REQ-003 SHALL have parameter IWIDTH, default 32, instruction word width.
REQ-004 SHALL have parameter PCSTEP, default 4, PC increment per fetched word.
REQ-005 SHALL have parameter RESETPC, default 0, PC value after reset.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 Clock  input  1  rising-edge clock.
REQ-008 Reset  input  1  synchronous active-high reset.
REQ-009 InstrMem  input  IWIDTH  word at InstrAddr, combinational, same cycle.
REQ-010 InstrAddr  output  AWIDTH  fetch PC.
REQ-011 BranchTaken  input  1  redirect request.
REQ-012 BranchAddr  input  AWIDTH  redirect target.
REQ-013 Ready  input  1  decode accepts the head entry this cycle.
REQ-014 Valid  output  1  head entry present.
REQ-015 InstrOut  output  IWIDTH  head instruction.
REQ-016 PCOut  output  AWIDTH  head instruction address.
REQ-017 Count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-018 Push SHALL occur when BranchTaken=0 and (Count<DEPTH or pop); pushes {InstrMem, InstrAddr}; InstrAddr advances by PCSTEP, wrapping modulo 2^AWIDTH.
REQ-019 Pop SHALL occur when Valid=1 and Ready=1; head advances one entry.
REQ-020 Full with pop in the same cycle SHALL push and pop; Count unchanged.
REQ-021 Full without pop SHALL hold InstrAddr and storage; no push.
REQ-022 BranchTaken=1 SHALL take priority: next cycle Count=0, InstrAddr=BranchAddr, no push, any pop discarded.
REQ-023 Valid SHALL equal (Count!=0); InstrOut/PCOut SHALL be the oldest entry, don't-care when Valid=0.
REQ-024 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 Latency without bypass SHALL be one cycle from push to Valid.
REQ-026 Count SHALL never exceed DEPTH nor underflow.

Reset
REQ-027 Reset=1 at a clock edge SHALL set InstrAddr=RESETPC, Count=0, pointers=0, Valid=0.
REQ-028 Reset SHALL override BranchTaken, push and pop in the same cycle, including mid-operation with a full queue.
REQ-029 Entry storage SHALL need no reset.

Configuration
REQ-030 Macro FETCH_QUEUE_BYPASS_EN defined: when Count=0, BranchTaken=0 and Reset=0, Valid=1, InstrOut=InstrMem, PCOut=InstrAddr combinationally; if Ready=1 the word is consumed and not stored, and InstrAddr advances.
REQ-031 With bypass and Count=0, Ready=0 SHALL store the word normally.
REQ-032 Macro undefined: no combinational path from InstrMem to outputs; REQ-025 latency applies.

Verification
REQ-033 Reset, Ready=1 constant, InstrMem=addr-tagged words -> PCOut sequence 0,4,8,...; Valid from cycle 2 (no bypass) or cycle 1 (bypass).
REQ-034 Ready=0 for 6 cycles, DEPTH=4 -> Count 1,2,3,4,4,4; InstrAddr holds at 16; then Ready=1 -> PCOut 0,4,8,12,16 in order.
REQ-035 Full queue, Ready=1 one cycle -> Count stays 4, pops PC 0, pushes PC 16.
REQ-036 Count=3, BranchTaken=1, BranchAddr=0x0100 -> next cycle Valid=0, Count=0, InstrAddr=0x0100; first PCOut after is 0x0100.
REQ-037 InstrAddr=0xFFFC, AWIDTH=16 -> next pushed PC 0x0000.
REQ-038 Full queue, Reset=1 with BranchTaken=1 and Ready=1 -> Count=0, InstrAddr=RESETPC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches one word per cycle into a DEPTH-entry FIFO and presents the oldest entry to decode.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int AWIDTH  = 16,
   parameter int IWIDTH  = 32,
   parameter int PCSTEP  = 4,
   parameter int RESETPC = 0
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic [IWIDTH-1:0]          InstrMem,
   output logic [AWIDTH-1:0]          InstrAddr,
   input  logic                       BranchTaken,
   input  logic [AWIDTH-1:0]          BranchAddr,
   input  logic                       Ready,
   output logic                       Valid,
   output logic [IWIDTH-1:0]          InstrOut,
   output logic [AWIDTH-1:0]          PCOut,
   output logic [$clog2(DEPTH+1)-1:0] Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTHC = CW'(DEPTH);

   logic [IWIDTH-1:0] instrStore [DEPTH];
   logic [AWIDTH-1:0] pcStore    [DEPTH];
   logic [PW-1:0]     wrPtr, rdPtr;
   logic [CW-1:0]     count;
   logic              qValid, popQ, advance, push;

   // Handshake: a word leaves the queue only in a cycle where Valid and Ready are both high;
   // Valid never depends on Ready, and a redirect discards whatever pop was offered.
   assign qValid  = (count != '0);
   assign popQ    = qValid && Ready && !BranchTaken;
   assign advance = !BranchTaken && ((count < DEPTHC) || popQ);

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypassHit;
   assign bypassHit = (count == '0) && !BranchTaken && !Reset;
   // A bypassed word accepted by decode advances the PC but is never written.
   assign push = advance && !(bypassHit && Ready);

   always_comb begin
      Valid    = qValid;
      InstrOut = instrStore[rdPtr];
      PCOut    = pcStore[rdPtr];
      if (bypassHit) begin
         Valid    = 1'b1;
         InstrOut = InstrMem;
         PCOut    = InstrAddr;
      end
   end
`else
   assign push     = advance;
   assign Valid    = qValid;
   assign InstrOut = instrStore[rdPtr];
   assign PCOut    = pcStore[rdPtr];
`endif

   assign Count = count;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         InstrAddr <= AWIDTH'(RESETPC);
         count     <= '0;
         wrPtr     <= '0;
         rdPtr     <= '0;
      end else if (BranchTaken) begin
         InstrAddr <= BranchAddr;
         count     <= '0;
         wrPtr     <= '0;
         rdPtr     <= '0;
      end else begin
         if (advance) InstrAddr <= InstrAddr + AWIDTH'(PCSTEP);
         if (push)    wrPtr     <= wrPtr + 1'b1;
         if (popQ)    rdPtr     <= rdPtr + 1'b1;
         case ({push, popQ})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; pointers and count alone define which entries are live.
   always_ff @(posedge Clock) begin
      if (push && !Reset) begin
         instrStore[wrPtr] <= InstrMem;
         pcStore[wrPtr]    <= InstrAddr;
      end
   end

endmodule
